memory_request_unit: RTL and testbench
======================================

# memory_request_unit

Memory-stage data-access controller that consumes the EX/MEM latch outputs and drives the dcache request interface. It holds dREN/dWEN until dhit, backpressures the pipeline through mem_stall, captures load data for MEM/WB, and implements the LL/SC link register. It sits between the EX/MEM latch and the dcache, and its mem_stall feeds the same stall logic that freezes that latch.

## Interface
- No parameters; word size fixed at 32 bits.
- CLK  in  1  clock, rising-edge.
- nRST  in  1  reset, asynchronous, active-low.
- dREN_in, dWEN_in, datomic_in  in  1 each  load, store and atomic flags from the EX/MEM latch.
- halt_in  in  1  halt flag from the EX/MEM latch.
- addr_in  in  32  effective address, the ALU result from the latch.
- store_data_in  in  32  store data, rdat2 from the latch.
- pipe_stall  in  1  other stall sources; the latch advances only when pipe_stall=0 and mem_stall=0.
- snoop_inv  in  1  remote write or invalidate observed this cycle.
- snoop_addr  in  32  address of snoop_inv.
- dhit  in  1  dcache completion for the current request.
- dmemload  in  32  dcache read data, valid when dhit=1.
- dmemREN, dmemWEN  out  1 each  dcache request strobes.
- dmemaddr  out  32  request address, equal to addr_in.
- dmemstore  out  32  store data, equal to store_data_in.
- mem_stall  out  1  freeze the EX/MEM latch and the upstream stages.
- load_data  out  32  registered result for MEM/WB: load data or SC status.
- halt_out  out  1  sticky halt to the system.

## Operation
- States: IDLE, BUSY, DONE. Registers: state, link_valid, link_addr[31:0], load_data, halt_out.
- req = dREN_in | dWEN_in.
- sc = datomic_in & dWEN_in.
- ll = datomic_in & dREN_in.
- sc_ok = sc & link_valid & (link_addr[31:2]==addr_in[31:2]) & !(snoop_inv & snoop_addr[31:2]==addr_in[31:2]).
- IDLE, req=0: no request, mem_stall=0.
- IDLE, req=1, and not (sc & !sc_ok):
  - dmemREN=dREN_in, dmemWEN=dWEN_in combinationally in the same cycle.
  - mem_stall=!dhit.
  - dhit=1 -> DONE. dhit=0 -> BUSY.
- IDLE, sc & !sc_ok (failed SC):
  - No request; mem_stall=1 for that cycle.
  - load_data<=0; link_valid<=0; -> DONE.
- BUSY:
  - Hold dmemREN/dmemWEN; mem_stall=!dhit.
  - dhit -> DONE.
- At dhit:
  - Load: load_data<=dmemload.
  - SC: load_data<=1.
  - Plain store: load_data unchanged.
- DONE:
  - No request, mem_stall=0, load_data held.
  - pipe_stall=0 -> IDLE. pipe_stall=1 -> stay in DONE; the same held instruction is never re-issued.
- Link register:
  - LL completing on dhit: link_valid<=1, link_addr<=addr_in.
  - Cleared by any SC completion, pass or fail.
  - Cleared by snoop_inv with snoop_addr[31:2]==link_addr[31:2].
  - Cleared by a local plain store completing to link_addr (word match).
  - Set and clear in the same cycle: clear wins.
- Halt: halt_in=1 while state==IDLE and req=0 -> halt_out<=1, held until reset. halt_out is never set while a request is in flight.
- Address compares use bits [31:2] only; bits [1:0] are ignored.

## Timing
- Reset (nRST low, async): state=IDLE, link_valid=0, link_addr=0, load_data=0, halt_out=0.
  - Request outputs fall combinationally with the latch, which also resets to zero.
- Reset mid-BUSY: request dropped immediately; no load_data update; link cleared.
- Zero-wait hit (dhit in the issue cycle): mem_stall=0 that cycle. load_data is valid the next cycle, aligned with the latch advance into MEM/WB.
- Miss of N cycles: mem_stall=1 for N cycles; dmemREN/dmemWEN are stable and continuous until dhit.
- Back-to-back memory ops: DONE lasts at least 1 cycle, so the second request issues no earlier than 1 cycle after the first dhit.
- dhit while state==DONE or (IDLE & !req): ignored.
- Failed SC: exactly one stall cycle, zero cache traffic.

## Test plan
- lw addr=0x100, dhit after 3 cycles, dmemload=0xDEADBEEF:
  - dmemREN high and mem_stall high for 3 cycles.
  - Next cycle load_data=0xDEADBEEF; state passes through DONE to IDLE.
- ll 0x200 (dhit), then sc 0x200 store 0x5:
  - dmemWEN pulses with dmemstore=0x5; load_data=1; link_valid=0 afterward.
- ll 0x200, then snoop_inv snoop_addr=0x202, then sc 0x200:
  - No dmemWEN; load_data=0; one stall cycle.
- sw completes with pipe_stall=1 held 4 cycles:
  - State stays DONE; dmemWEN stays low throughout (no re-issue).
  - IDLE on the cycle after pipe_stall falls.
- halt_in=1 with req=0: halt_out=1 the next cycle and held. halt_in=1 while BUSY: halt_out stays 0.
- nRST asserted during BUSY: dmemREN falls at once; load_data=0, link_valid=0, state=IDLE.

Source files
------------

// File: rtl/memory_request_unit.sv
// memory_request_unit: MEM-stage dcache request controller with LL/SC link register.
// Holds the dcache request until dhit, stalls the EX/MEM latch while waiting,
// registers load data / SC status for MEM/WB and latches a sticky halt.
module memory_request_unit (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dREN_in,
  input  logic        dWEN_in,
  input  logic        datomic_in,
  input  logic        halt_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  input  logic        pipe_stall,
  input  logic        snoop_inv,
  input  logic [31:0] snoop_addr,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic [31:0] load_data,
  output logic        halt_out
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LINK_W = WORD_W - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                link_valid_q, link_valid_d;
  logic [LINK_W-1:0]   link_word_q, link_word_d;
  logic [WORD_W-1:0]   load_data_q, load_data_d;
  logic                halt_q, halt_d;

  logic req, sc, ll, sc_ok, snoop_hit_req, done_hit, sc_fail, link_clear;
  logic unused_snoop_bits;

  // Request decode and store-conditional eligibility.
  assign req           = dREN_in | dWEN_in;
  assign sc            = datomic_in & dWEN_in;
  assign ll            = datomic_in & dREN_in;
  assign snoop_hit_req = snoop_inv & (snoop_addr[31:2] == addr_in[31:2]);
  assign sc_ok         = sc & link_valid_q & (link_word_q == addr_in[31:2]) & ~snoop_hit_req;

  // Byte offset of the snoop address never participates in word compares.
  assign unused_snoop_bits = ^snoop_addr[1:0];

  assign dmemaddr  = addr_in;
  assign dmemstore = store_data_in;
  assign load_data = load_data_q;
  assign halt_out  = halt_q;

  // State and result registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      link_valid_q <= 1'b0;
      link_word_q  <= '0;
      load_data_q  <= '0;
      halt_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      link_valid_q <= link_valid_d;
      link_word_q  <= link_word_d;
      load_data_q  <= load_data_d;
      halt_q       <= halt_d;
    end
  end

  // Next-state, request strobes, stall, result capture and link maintenance.
  always_comb begin
    state_d      = state_q;
    link_valid_d = link_valid_q;
    link_word_d  = link_word_q;
    load_data_d  = load_data_q;
    halt_d       = halt_q;
    dmemREN      = 1'b0;
    dmemWEN      = 1'b0;
    mem_stall    = 1'b0;
    done_hit     = 1'b0;
    sc_fail      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (sc && !sc_ok) begin
            // Failed SC: no cache traffic, one stall cycle, status 0.
            sc_fail     = 1'b1;
            mem_stall   = 1'b1;
            load_data_d = '0;
            state_d     = DONE;
          end else begin
            dmemREN   = dREN_in;
            dmemWEN   = dWEN_in;
            mem_stall = ~dhit;
            done_hit  = dhit;
            state_d   = dhit ? DONE : BUSY;
          end
        end else if (halt_in) begin
          halt_d = 1'b1;
        end
      end
      BUSY: begin
        dmemREN   = dREN_in;
        dmemWEN   = dWEN_in;
        mem_stall = ~dhit;
        done_hit  = dhit;
        if (dhit) state_d = DONE;
      end
      DONE: begin
        if (!pipe_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Result capture on completion; plain stores leave load_data alone.
    if (done_hit) begin
      if (dREN_in)  load_data_d = dmemload;
      else if (sc)  load_data_d = WORD_W'(1);
    end

    // Link set by a completing LL; any clear source in the same cycle wins.
    if (done_hit && ll) begin
      link_valid_d = 1'b1;
      link_word_d  = addr_in[31:2];
    end
    link_clear = (done_hit && sc) || sc_fail
              || (done_hit && dWEN_in && !datomic_in && (addr_in[31:2] == link_word_d))
              || (snoop_inv && (snoop_addr[31:2] == link_word_d));
    if (link_clear) link_valid_d = 1'b0;

    // Request and stall drop immediately while reset is asserted.
    if (!nRST) begin
      dmemREN   = 1'b0;
      dmemWEN   = 1'b0;
      mem_stall = 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_request_unit.sv
// Testbench for memory_request_unit: per-cycle vector table plus a reset-mid-BUSY sequence.
module tb_memory_request_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        dREN_in, dWEN_in, datomic_in, halt_in;
  logic [31:0] addr_in, store_data_in;
  logic        pipe_stall, snoop_inv;
  logic [31:0] snoop_addr;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dmemREN, dmemWEN, mem_stall, halt_out;
  logic [31:0] dmemaddr, dmemstore, load_data;

  int n_total = 0;
  int n_pass  = 0;

  memory_request_unit dut (
    .CLK(CLK), .nRST(nRST),
    .dREN_in(dREN_in), .dWEN_in(dWEN_in), .datomic_in(datomic_in), .halt_in(halt_in),
    .addr_in(addr_in), .store_data_in(store_data_in),
    .pipe_stall(pipe_stall), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
    .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .load_data(load_data), .halt_out(halt_out)
  );

  always #5 CLK = ~CLK;

  // One cycle of latch/cache inputs plus outputs expected in that same cycle.
  typedef struct {
    logic        ren, wen, atom, halt;
    logic [31:0] addr, sdata;
    logic        pstall, sinv;
    logic [31:0] saddr;
    logic        dh;
    logic [31:0] dload;
    logic        e_ren, e_wen, e_stall;
    logic [31:0] e_ld;
    logic        e_halt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic ren, wen, atom, halt, input logic [31:0] addr, sdata,
                             input logic pstall, sinv, input logic [31:0] saddr,
                             input logic dh, input logic [31:0] dload,
                             input logic e_ren, e_wen, e_stall, input logic [31:0] e_ld,
                             input logic e_halt);
    vec_t r;
    r.ren = ren; r.wen = wen; r.atom = atom; r.halt = halt;
    r.addr = addr; r.sdata = sdata; r.pstall = pstall; r.sinv = sinv; r.saddr = saddr;
    r.dh = dh; r.dload = dload;
    r.e_ren = e_ren; r.e_wen = e_wen; r.e_stall = e_stall; r.e_ld = e_ld; r.e_halt = e_halt;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
  endtask

  task automatic drive(input vec_t r);
    dREN_in = r.ren; dWEN_in = r.wen; datomic_in = r.atom; halt_in = r.halt;
    addr_in = r.addr; store_data_in = r.sdata; pipe_stall = r.pstall;
    snoop_inv = r.sinv; snoop_addr = r.saddr; dhit = r.dh; dmemload = r.dload;
  endtask

  task automatic check(input vec_t r, input int idx);
    chk("dmemREN",   idx, 32'(dmemREN),   32'(r.e_ren));
    chk("dmemWEN",   idx, 32'(dmemWEN),   32'(r.e_wen));
    chk("mem_stall", idx, 32'(mem_stall), 32'(r.e_stall));
    chk("load_data", idx, load_data,      r.e_ld);
    chk("halt_out",  idx, 32'(halt_out),  32'(r.e_halt));
    chk("dmemaddr",  idx, dmemaddr,       r.addr);
    chk("dmemstore", idx, dmemstore,      r.sdata);
  endtask

  // Drive just after the rising edge, sample at the falling edge.
  task automatic run(input vec_t r, input int idx);
    @(posedge CLK); #1;
    drive(r);
    @(negedge CLK);
    check(r, idx);
  endtask

  vec_t idle_v;

  initial begin
    idle_v = v(0,0,0,0, 32'h0,32'h0, 0,0,32'h0, 0,32'h0, 0,0,0, 32'h0, 0);
    drive(idle_v);
    nRST = 1'b0;
    #1;
    chk("reset_load_data", -1, load_data, 32'h0);
    chk("reset_halt_out",  -1, 32'(halt_out), 32'h0);
    chk("reset_dmemREN",   -1, 32'(dmemREN), 32'h0);
    repeat (2) @(posedge CLK);
    @(negedge CLK); nRST = 1'b1;

    //        ren wen at hlt addr        sdata      ps si saddr      dh dload         eR eW eS e_ld          eH
    // lw 0x100 with three miss cycles, then a zero-wait lw
    vecs.push_back(v(0,0,0,0, 32'h0,     32'h0,     0,0,32'h0,     0,32'h0,        0,0,0, 32'h0,        0));
    vecs.push_back(v(1,0,0,0, 32'h100,   32'h0,     0,0,32'h0,     0,32'h0,        1,0,1, 32'h0,        0));
    vecs.push_back(v(1,0,0,0, 32'h100,   32'h0,     0,0,32'h0,     0,32'h0,        1,0,1, 32'h0,        0));
    vecs.push_back(v(1,0,0,0, 32'h100,   32'h0,     0,0,32'h0,     0,32'h0,        1,0,1, 32'h0,        0));
    vecs.push_back(v(1,0,0,0, 32'h100,   32'h0,     0,0,32'h0,     1,32'hDEADBEEF, 1,0,0, 32'h0,        0));
    vecs.push_back(v(0,0,0,0, 32'h0,     32'h0,     0,0,32'h0,     0,32'h0,        0,0,0, 32'hDEADBEEF, 0));
    vecs.push_back(v(1,0,0,0, 32'h104,   32'h0,     0,0,32'h0,     1,32'h11111111, 1,0,0, 32'hDEADBEEF, 0));
    vecs.push_back(v(0,0,0,0, 32'h0,     32'h0,     0,0,32'h0,     0,32'h0,        0,0,0, 32'h11111111, 0));
    // ll 0x200, sc 0x200 succeeds after one miss, repeat sc fails (link gone)
    vecs.push_back(v(1,0,1,0, 32'h200,   32'h0,     0,0,32'h0,     1,32'hAAAA0000, 1,0,0, 32'h11111111, 0));
    vecs.push_back(v(0,0,0,0, 32'h0,     32'h0,     0,0,32'h0,     0,32'h0,        0,0,0, 32'hAAAA0000, 0));
    vecs.push_back(v(0,1,1,0, 32'h200,   32'h5,     0,0,32'h0,     0,32'h0,        0,1,1, 32'hAAAA0000, 0));
    vecs.push_back(v(0,1,1,0, 32'h200,   32'h5,     0,0,32'h0,     1,32'h0,        0,1,0, 32'hAAAA0000, 0));
    vecs.push_back(v(0,0,0,0, 32'h0,     32'h0,     0,0,32'h0,     0,32'h0,        0,0,0, 32'h1,        0));
    vecs.push_back(v(0,1,1,0, 32'h200,   32'h5,     0,0,32'h0,     0,32'h0,        0,0,1, 32'h1,        0));
    vecs.push_back(v(0,1,1,0, 32'h200,   32'h5,     0,0,32'h0,     0,32'h0,        0,0,0, 32'h0,        0));
    vecs.push_back(v(0,0,0,0, 32'h0,     32'h0,     0,0,32'h0,     0,32'h0,        0,0,0, 32'h0,        0));
    // ll 0x200, snoop 0x202 (same word) kills link, sc fails without traffic
    vecs.push_back(v(1,0,1,0, 32'h200,   32'h0,     0,0,32'h0,     1,32'h12345678, 1,0,0, 32'h0,        0));
    vecs.push_back(v(0,0,0,0, 32'h0,     32'h0,     0,1,32'h202,   0,32'h0,        0,0,0, 32'h12345678, 0));
    vecs.push_back(v(0,1,1,0, 32'h200,   32'h5,     0,0,32'h0,     0,32'h0,        0,0,1, 32'h12345678, 0));
    vecs.push_back(v(0,1,1,0, 32'h200,   32'h5,     0,0,32'h0,     0,32'h0,        0,0,0, 32'h0,        0));
    // snoop to the next word leaves the link alone; zero-wait sc succeeds
    vecs.push_back(v(1,0,1,0, 32'h300,   32'h0,     0,0,32'h0,     1,32'hCAFE0001, 1,0,0, 32'h0,        0));
    vecs.push_back(v(0,0,0,0, 32'h0,     32'h0,     0,1,32'h304,   0,32'h0,        0,0,0, 32'hCAFE0001, 0));
    vecs.push_back(v(0,1,1,0, 32'h300,   32'h9,     0,0,32'h0,     1,32'h0,        0,1,0, 32'hCAFE0001, 0));
    vecs.push_back(v(0,0,0,0, 32'h0,     32'h0,     0,0,32'h0,     0,32'h0,        0,0,0, 32'h1,        0));
    // snoop to the sc word in the sc issue cycle fails the sc
    vecs.push_back(v(1,0,1,0, 32'h400,   32'h0,     0,0,32'h0,     1,32'h0BADF00D, 1,0,0, 32'h1,        0));
    vecs.push_back(v(0,0,0,0, 32'h0,     32'h0,     0,0,32'h0,     0,32'h0,        0,0,0, 32'h0BADF00D, 0));
    vecs.push_back(v(0,1,1,0, 32'h400,   32'h3,     0,1,32'h401,   1,32'h0,        0,0,1, 32'h0BADF00D, 0));
    vecs.push_back(v(0,1,1,0, 32'h400,   32'h3,     0,0,32'h0,     0,32'h0,        0,0,0, 32'h0,        0));
    // local plain store to the linked word clears the link; store keeps load_data
    vecs.push_back(v(1,0,1,0, 32'h500,   32'h0,     0,0,32'h0,     1,32'h55,       1,0,0, 32'h0,        0));
    vecs.push_back(v(0,0,0,0, 32'h0,     32'h0,     0,0,32'h0,     0,32'h0,        0,0,0, 32'h55,       0));
    vecs.push_back(v(0,1,0,0, 32'h503,   32'hEE,    0,0,32'h0,     1,32'h0,        0,1,0, 32'h55,       0));
    vecs.push_back(v(0,0,0,0, 32'h0,     32'h0,     0,0,32'h0,     0,32'h0,        0,0,0, 32'h55,       0));
    vecs.push_back(v(0,1,1,0, 32'h500,   32'h1,     0,0,32'h0,     1,32'h0,        0,0,1, 32'h55,       0));
    vecs.push_back(v(0,1,1,0, 32'h500,   32'h1,     0,0,32'h0,     0,32'h0,        0,0,0, 32'h0,        0));
    // sw held by pipe_stall: DONE persists, no re-issue despite stray dhit
    vecs.push_back(v(0,1,0,0, 32'h600,   32'h77,    1,0,32'h0,     1,32'h0,        0,1,0, 32'h0,        0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(v(0,1,0,0, 32'h600, 32'h77,    1,0,32'h0,     1,32'h0,        0,0,0, 32'h0,        0));
    vecs.push_back(v(0,1,0,0, 32'h600,   32'h77,    0,0,32'h0,     1,32'h0,        0,0,0, 32'h0,        0));
    vecs.push_back(v(1,0,0,0, 32'h604,   32'h0,     0,0,32'h0,     1,32'h00604604, 1,0,0, 32'h0,        0));
    vecs.push_back(v(0,0,0,0, 32'h0,     32'h0,     0,0,32'h0,     0,32'h0,        0,0,0, 32'h00604604, 0));
    // halt ignored while busy and in DONE, latched from idle and then sticky
    vecs.push_back(v(1,0,0,1, 32'h700,   32'h0,     0,0,32'h0,     0,32'h0,        1,0,1, 32'h00604604, 0));
    vecs.push_back(v(1,0,0,1, 32'h700,   32'h0,     0,0,32'h0,     1,32'h70,       1,0,0, 32'h00604604, 0));
    vecs.push_back(v(0,0,0,1, 32'h0,     32'h0,     0,0,32'h0,     0,32'h0,        0,0,0, 32'h70,       0));
    vecs.push_back(v(0,0,0,1, 32'h0,     32'h0,     0,0,32'h0,     0,32'h0,        0,0,0, 32'h70,       0));
    vecs.push_back(v(0,0,0,0, 32'h0,     32'h0,     0,0,32'h0,     1,32'hFFFF,     0,0,0, 32'h70,       1));
    vecs.push_back(v(0,0,0,0, 32'h0,     32'h0,     0,0,32'h0,     0,32'h0,        0,0,0, 32'h70,       1));
    // ll 0x900 to set a link ahead of the reset sequence
    vecs.push_back(v(1,0,1,0, 32'h900,   32'h0,     0,0,32'h0,     1,32'h99,       1,0,0, 32'h70,       1));
    vecs.push_back(v(0,0,0,0, 32'h0,     32'h0,     0,0,32'h0,     0,32'h0,        0,0,0, 32'h99,       1));
    vecs.push_back(v(1,0,0,0, 32'h800,   32'h0,     0,0,32'h0,     0,32'h0,        1,0,1, 32'h99,       1));

    foreach (vecs[i]) run(vecs[i], i);

    // Reset asserted mid-BUSY with the lw still on the latch outputs.
    @(posedge CLK); #2;
    nRST = 1'b0;
    dhit = 1'b1; dmemload = 32'hBAD0BAD0;
    #1;
    chk("rst_busy_dmemREN",   100, 32'(dmemREN),   32'h0);
    chk("rst_busy_mem_stall", 100, 32'(mem_stall), 32'h0);
    chk("rst_busy_load_data", 100, load_data,      32'h0);
    chk("rst_busy_halt_out",  100, 32'(halt_out),  32'h0);
    @(posedge CLK); #1;
    chk("rst_hold_load_data", 101, load_data,      32'h0);
    drive(idle_v);
    @(negedge CLK); nRST = 1'b1;
    // Link was cleared by reset: sc 0x900 fails with one stall cycle.
    run(v(0,1,1,0, 32'h900, 32'h4, 0,0,32'h0, 1,32'h0, 0,0,1, 32'h0, 0), 102);
    run(v(0,0,0,0, 32'h0,   32'h0, 0,0,32'h0, 0,32'h0, 0,0,0, 32'h0, 0), 103);
    run(v(1,0,0,0, 32'hA00, 32'h0, 0,0,32'h0, 1,32'h1234, 1,0,0, 32'h0, 0), 104);
    run(v(0,0,0,0, 32'h0,   32'h0, 0,0,32'h0, 0,32'h0, 0,0,0, 32'h1234, 0), 105);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
